// File: rtl/mul_ctrl_pkg.sv
// Shared types for the repeated-addition multiplier slice.
// FSM state encoding and the datapath width used by B counter and P.
package mul_pkg;

  // Width shared by the B down-counter and the P accumulator
  localparam int unsigned MUL_DW = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_ACC   = 3'd3,
    S_DONE  = 3'd4
  } mul_state_t;

  function automatic logic is_busy(
    input mul_state_t s
  );
    return (s == S_LOAD) ||
           (s == S_CHECK) ||
           (s == S_ACC);
  endfunction

endpackage

// File: rtl/mul_ctrl.sv
// Control FSM for the repeated-addition multiplier (P = A * B).
// Drives A/B/P strobes from a registered Moore decode of the state.
//
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   start       : request a multiply (sampled in IDLE and DONE)
//   abort       : synchronous abort back to IDLE
//   b_is_zero   : B counter == 0, from the datapath
//   ld_a, ld_b, clr_p : operand load / accumulator clear (LOAD)
//   ld_p, dec_b : accumulate and count down (ACC)
//   busy        : LOAD, CHECK or ACC
//   done        : one-cycle completion pulse
//   err         : watchdog error flag
//
// Build option MUL_CTRL_WDOG_EN adds an ACC-visit watchdog; without it
// err is tied low and the port list is unchanged.
module mul_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned       ITER_W   = 16,
  parameter logic [ITER_W-1:0] MAX_ITER = 16'hFFFF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic b_is_zero,
  output logic ld_a,
  output logic ld_b,
  output logic clr_p,
  output logic ld_p,
  output logic dec_b,
  output logic busy,
  output logic done,
  output logic err
);

  mul_state_t r_state;
  mul_state_t w_next;

  logic w_abort;
  logic w_hit;
  logic w_trip;

  logic r_ld_a;
  logic r_ld_b;
  logic r_clr_p;
  logic r_ld_p;
  logic r_dec_b;
  logic r_busy;
  logic r_done;

  // abort has no effect while already idle
  assign w_abort = abort && (r_state != S_IDLE);

`ifdef MUL_CTRL_WDOG_EN
  logic [ITER_W-1:0] r_iter;
  logic              r_err;

  assign w_hit = (r_iter == MAX_ITER);
`else
  assign w_hit = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    w_trip = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start)
          w_next = S_LOAD;
      end
      S_LOAD: begin
        w_next = S_CHECK;
      end
      S_CHECK: begin
        if (b_is_zero) begin
          w_next = S_DONE;
        end else if (w_hit) begin
          w_next = S_DONE;
          w_trip = 1'b1;
        end else begin
          w_next = S_ACC;
        end
      end
      S_ACC: begin
        w_next = S_CHECK;
      end
      S_DONE: begin
        w_next = start ? S_LOAD : S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (w_abort)
      w_next = S_IDLE;
  end

  // Outputs are registered from the next state, so each output
  // register always equals a decode of the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ld_a  <= 1'b0;
      r_ld_b  <= 1'b0;
      r_clr_p <= 1'b0;
      r_ld_p  <= 1'b0;
      r_dec_b <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ld_a  <= (w_next == S_LOAD);
      r_ld_b  <= (w_next == S_LOAD);
      r_clr_p <= (w_next == S_LOAD);
      r_ld_p  <= (w_next == S_ACC);
      r_dec_b <= (w_next == S_ACC);
      r_busy  <= is_busy(w_next);
      r_done  <= (w_next == S_DONE);
    end
  end

`ifdef MUL_CTRL_WDOG_EN
  // Counts ACC visits of the current operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iter <= '0;
    end else if (r_state == S_LOAD) begin
      r_iter <= '0;
    end else if (r_state == S_ACC) begin
      r_iter <= r_iter + 1'b1;
    end
  end

  // Set together with the DONE entry it causes; held until the
  // next operation starts or the run is aborted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_abort) begin
      r_err <= 1'b0;
    end else if (w_next == S_LOAD) begin
      r_err <= 1'b0;
    end else if (w_trip) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign ld_a  = r_ld_a;
  assign ld_b  = r_ld_b;
  assign clr_p = r_clr_p;
  assign ld_p  = r_ld_p;
  assign dec_b = r_dec_b;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl with a behavioural A/B/P datapath.
// Done pulses are scored against a queue of expected cycle/product.
module tb_mul_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic b_is_zero;
  logic ld_a, ld_b, clr_p, ld_p, dec_b, busy, done, err;

  always #5 clk = ~clk;

  mul_ctrl #(
    .ITER_W  (16),
    .MAX_ITER(16'd4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .b_is_zero(b_is_zero),
    .ld_a     (ld_a),
    .ld_b     (ld_b),
    .clr_p    (clr_p),
    .ld_p     (ld_p),
    .dec_b    (dec_b),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] a_val = '0;
  logic [15:0] b_val = '0;
  logic [15:0] a_reg = '0;
  logic [15:0] bcnt  = '0;
  logic [15:0] p_reg = '0;
  logic        stuck = 1'b0;
  int unsigned cyc   = 0;

  typedef struct {
    int unsigned cyc;
    logic [15:0] prod;
  } exp_t;

  exp_t exp_q[$];

  logic [7:0] obs;
  assign obs = {ld_a, ld_b, clr_p, ld_p, dec_b, busy, done, err};

  // datapath model: A register, B down-counter, P accumulator
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ld_a) a_reg <= a_val;
    if (clr_p) p_reg <= '0;
    else if (ld_p) p_reg <= p_reg + a_reg;
    if (ld_b) bcnt <= b_val;
    else if (dec_b && bcnt != 0) bcnt <= bcnt - 1'b1;
  end

  assign b_is_zero = stuck ? 1'b0 : (bcnt == '0);

  // expected {ld_a,ld_b,clr_p,ld_p,dec_b,busy,done,err} in cycle c
  // of an operation with B=n (cycle 1 = LOAD)
  function automatic logic [7:0] exp_vec(int n, int c);
    logic l, acc, bz, dn;
    l   = (c == 1);
    acc = (c >= 3) && (c <= 2*n+1) && (c % 2 == 1);
    bz  = (c >= 1) && (c <= 2*n+2);
    dn  = (c == 2*n+3);
    return {l, l, l, acc, acc, bz, dn, 1'b0};
  endfunction

  // scoreboard + invariants
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (ld_b && dec_b) begin
        errors++;
        $display("FAIL ld_b_dec_b cyc=%0d both asserted", cyc);
      end
      checks++;
      if (!stuck && dec_b && bcnt == 0) begin
        errors++;
        $display("FAIL dec_from_zero cyc=%0d", cyc);
      end
      if (done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done cyc=%0d", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (cyc !== e.cyc || p_reg !== e.prod) begin
            errors++;
            $display("FAIL done_sb cyc=%0d p=%0d expected cyc=%0d p=%0d",
                     cyc, p_reg, e.cyc, e.prod);
          end
        end
      end
    end
  end

  // call at a negedge; returns at cycle 1 (LOAD)
  task automatic kick(input logic [15:0] a, input logic [15:0] b,
                      input bit push, input int lat,
                      input logic [15:0] prod);
    exp_t e;
    a_val = a;
    b_val = b;
    start = 1'b1;
    if (push) begin
      e.cyc  = cyc + lat;
      e.prod = prod;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold obs=%b expected=%b", obs, 8'h00);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 8'h00) begin
        errors++;
        $display("FAIL reset_idle obs=%b expected=%b", obs, 8'h00);
      end
    end
  endtask

  task automatic test_op(input logic [15:0] a, input int n);
    logic [7:0] ev;
    logic [15:0] bn;
    bn = 16'(n);
    @(negedge clk);
    kick(a, bn, 1'b1, 2*n+3, a * bn);
    for (int c = 1; c <= 2*n+4; c++) begin
      ev = exp_vec(n, c);
      checks++;
      if (obs !== ev) begin
        errors++;
        $display("FAIL op_b%0d c=%0d obs=%b expected=%b", n, c, obs, ev);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ev;
    exp_t e;
    @(negedge clk);
    a_val = 16'd4;
    b_val = 16'd2;
    start = 1'b1;
    e.cyc = cyc + 7;  e.prod = 16'd8; exp_q.push_back(e);
    e.cyc = cyc + 12; e.prod = 16'd6; exp_q.push_back(e);
    @(negedge clk);
    for (int c = 1; c <= 13; c++) begin
      ev = (c <= 7) ? exp_vec(2, c) : exp_vec(1, c - 7);
      checks++;
      if (obs !== ev) begin
        errors++;
        $display("FAIL b2b c=%0d obs=%b expected=%b", c, obs, ev);
      end
      if (c == 2) begin
        a_val = 16'd6;
        b_val = 16'd1;
      end
      if (c == 8) start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    logic [7:0] ev;
    @(negedge clk);
    kick(16'd9, 16'd3, 1'b0, 0, '0);
    for (int c = 1; c <= 5; c++) begin
      ev = exp_vec(3, c);
      checks++;
      if (obs !== ev) begin
        errors++;
        $display("FAIL abort_pre c=%0d obs=%b expected=%b", c, obs, ev);
      end
      if (c == 5) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    for (int c = 6; c <= 7; c++) begin
      checks++;
      if (obs !== 8'h00) begin
        errors++;
        $display("FAIL abort_idle c=%0d obs=%b expected=%b", c, obs, 8'h00);
      end
      @(negedge clk);
    end
    test_op(16'd2, 2);
    // abort and start together in DONE: abort wins
    @(negedge clk);
    kick(16'd5, 16'd0, 1'b1, 3, 16'd0);
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    checks++;
    if (obs !== exp_vec(0, 3)) begin
      errors++;
      $display("FAIL abort_done_pre obs=%b expected=%b", obs, exp_vec(0, 3));
    end
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL abort_in_done obs=%b expected=%b", obs, 8'h00);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    kick(16'd3, 16'd4, 1'b1, 11, 16'd12);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL async_reset obs=%b expected=%b", obs, 8'h00);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL async_release obs=%b expected=%b", obs, 8'h00);
    end
  endtask

  task automatic test_watchdog();
    logic [7:0] ev;
    stuck = 1'b1;
    @(negedge clk);
`ifdef MUL_CTRL_WDOG_EN
    kick(16'd3, 16'd9, 1'b1, 11, 16'd12);
    for (int c = 1; c <= 12; c++) begin
      ev = exp_vec(4, c);
      if (c >= 11) ev[0] = 1'b1;
      checks++;
      if (obs !== ev) begin
        errors++;
        $display("FAIL wdog c=%0d obs=%b expected=%b", c, obs, ev);
      end
      @(negedge clk);
    end
    stuck = 1'b0;
    test_op(16'd2, 1);
`else
    kick(16'd3, 16'd9, 1'b0, 0, '0);
    for (int c = 1; c <= 40; c++) begin
      checks++;
      if (err !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL nowdog c=%0d err=%b done=%b busy=%b expected 0 0 1",
                 c, err, done, busy);
      end
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    stuck = 1'b0;
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL nowdog_abort obs=%b expected=%b", obs, 8'h00);
    end
    test_op(16'd2, 1);
`endif
  endtask

  initial begin
    test_reset();
    test_op(16'd7, 0);
    test_op(16'd5, 3);
    test_op(16'd3, 5);
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_watchdog();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover size=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
